// File: rtl/spi_client_sync.sv
// spi_client_sync: oversampled SPI client with host register bus, byte FIFOs, selectable mode and maskable interrupts.
module spi_client_sync #(
    parameter int FIFO_LOG2   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       busclk_i,
    input  logic       n_reset_i,
    input  logic       sck_i,
    input  logic       cs_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       slave_rdy_o,
    input  logic       master_rdy_i,
    input  logic [3:0] A_i,
    input  logic [7:0] D_i,
    output logic [7:0] D_o,
    input  logic       nWR_i,
    input  logic       nRD_i,
    output logic       interrupt_o
);
    localparam int S = SYNC_STAGES;
    localparam int L = FIFO_LOG2;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
    typedef logic [L:0] ptr_t;

    state_t state_q, state_d;
    logic [S-1:0] sck_sync_q, sck_sync_d, cs_sync_q, cs_sync_d;
    logic [S-1:0] mosi_sync_q, mosi_sync_d, mrdy_sync_q, mrdy_sync_d;
    logic sck_prev_q, cs_prev_q, mrdy_prev_q, nwr_prev_q, nrd_prev_q;
    logic slave_rdy_q, slave_rdy_d, cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic act_cpol_q, act_cpol_d, act_cpha_q, act_cpha_d, act_lsb_q, act_lsb_d;
    logic [4:0] ie_q, ie_d, flags_q, flags_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] tx_q, tx_d, rx_q, rx_d, do_q, do_d;
    logic miso_q, miso_d, irq_q, irq_d;
    ptr_t out_wp_q, out_wp_d, out_rp_q, out_rp_d, in_wp_q, in_wp_d, in_rp_q, in_rp_d;
    logic [7:0] out_mem [1<<L];
    logic [7:0] in_mem [1<<L];

    logic sck_s, cs_s, mosi_s, mrdy_s, wr, rd, clr, lead, trail, cs_fall, cs_rise;
    logic out_empty, out_full, in_empty, in_full, err_any;
    logic out_push, out_pop, in_push, in_pop, push_req, set_ov, set_ur, set_fr, set_te;
    logic [1:0] a;
    logic [7:0] load_b, status;
    logic unused_a;

    function automatic logic [8:0] drive(input logic [7:0] x, input logic lsb);
        return lsb ? {x[0], 1'b1, x[7:1]} : {x[7], x[6:0], 1'b1};
    endfunction

    assign unused_a  = ^A_i[3:2];
    assign a         = A_i[1:0];
    assign sck_s     = sck_sync_q[S-1];
    assign cs_s      = cs_sync_q[S-1];
    assign mosi_s    = mosi_sync_q[S-1];
    assign mrdy_s    = mrdy_sync_q[S-1];
    assign wr        = nwr_prev_q & ~nWR_i;
    assign rd        = nrd_prev_q & ~nRD_i;
    assign clr       = wr && a == 2'd1 && D_i[7];
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign lead      = (sck_s != act_cpol_q) && (sck_prev_q == act_cpol_q);
    assign trail     = (sck_s == act_cpol_q) && (sck_prev_q != act_cpol_q);
    assign out_empty = out_wp_q == out_rp_q;
    assign out_full  = (out_wp_q[L] != out_rp_q[L]) && (out_wp_q[L-1:0] == out_rp_q[L-1:0]);
    assign in_empty  = in_wp_q == in_rp_q;
    assign in_full   = (in_wp_q[L] != in_rp_q[L]) && (in_wp_q[L-1:0] == in_rp_q[L-1:0]);
    assign err_any   = |flags_q[2:0];
    assign load_b    = out_empty ? 8'hFF : out_mem[out_rp_q[L-1:0]];
    assign status    = {cs_s, slave_rdy_q, err_any, mrdy_s, out_full, out_empty, in_full, in_empty};

    always_comb begin
        sck_sync_d  = {sck_sync_q[S-2:0], sck_i};
        cs_sync_d   = {cs_sync_q[S-2:0], cs_i};
        mosi_sync_d = {mosi_sync_q[S-2:0], mosi_i};
        mrdy_sync_d = {mrdy_sync_q[S-2:0], master_rdy_i};
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        miso_d      = miso_q;
        act_cpol_d  = act_cpol_q;
        act_cpha_d  = act_cpha_q;
        act_lsb_d   = act_lsb_q;
        out_pop     = 1'b0;
        push_req    = 1'b0;
        set_ur      = 1'b0;
        set_fr      = 1'b0;
        set_te      = 1'b0;
        case (state_q)
            IDLE: if (cs_fall) begin
                state_d    = LOAD;
                act_cpol_d = cpol_q;
                act_cpha_d = cpha_q;
                act_lsb_d  = lsb_q;
            end
            LOAD: if (slave_rdy_q) begin
                out_pop = !out_empty;
                set_ur  = out_empty;
                if (act_cpha_q) tx_d = load_b;
                else {miso_d, tx_d} = drive(load_b, act_lsb_q);
                cnt_d   = 3'd0;
                state_d = SHIFT;
            end
            default: if (slave_rdy_q) begin
                // CPHA=0 skips the trailing edge that follows a byte's last sample: LOAD already drove the next bit
                if (act_cpha_q ? lead : (trail && cnt_q != 3'd0)) {miso_d, tx_d} = drive(tx_q, act_lsb_q);
                if (act_cpha_q ? trail : lead) begin
                    rx_d     = act_lsb_q ? {mosi_s, rx_q[7:1]} : {rx_q[6:0], mosi_s};
                    cnt_d    = cnt_q + 3'd1;
                    push_req = cnt_q == 3'd7;
                    state_d  = cnt_q == 3'd7 ? LOAD : SHIFT;
                end
            end
        endcase
        if (cs_rise) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            set_fr  = state_q == SHIFT && cnt_q != 3'd0;
            set_te  = 1'b1;
        end
        if (clr) begin
            cnt_d    = 3'd0;
            rx_d     = 8'h00;
            tx_d     = 8'hFF;
            out_pop  = 1'b0;
            push_req = 1'b0;
        end
        miso_d      = (state_d == IDLE || !slave_rdy_q) ? 1'b1 : miso_d;
        in_pop      = rd && a == 2'd0 && !in_empty && !clr;
        in_push     = push_req && (!in_full || in_pop);
        set_ov      = push_req && !in_push;
        out_push    = wr && a == 2'd0 && (!out_full || out_pop) && !clr;
        out_wp_d    = clr ? '0 : out_wp_q + ptr_t'(out_push);
        out_rp_d    = clr ? '0 : out_rp_q + ptr_t'(out_pop);
        in_wp_d     = clr ? '0 : in_wp_q + ptr_t'(in_push);
        in_rp_d     = clr ? '0 : in_rp_q + ptr_t'(in_pop);
        slave_rdy_d = cs_rise ? 1'b0 : (wr && a == 2'd1) ? D_i[0] : slave_rdy_q;
        cpol_d      = (wr && a == 2'd1) ? D_i[1] : cpol_q;
        cpha_d      = (wr && a == 2'd1) ? D_i[2] : cpha_q;
        lsb_d       = (wr && a == 2'd1) ? D_i[3] : lsb_q;
        ie_d        = (wr && a == 2'd2) ? D_i[4:0] : ie_q;
        flags_d     = (flags_q & ~((wr && a == 2'd3) ? D_i[4:0] : 5'd0))
                    | {mrdy_s != mrdy_prev_q, set_te, set_fr, set_ur, set_ov};
        do_d        = !rd ? do_q :
                      a == 2'd0 ? (in_empty ? 8'h00 : in_mem[in_rp_q[L-1:0]]) :
                      a == 2'd1 ? status :
                      a == 2'd2 ? {3'b000, ie_q} : {3'b000, flags_q};
        irq_d       = |(ie_q & {flags_q[4], flags_q[3], err_any, out_empty, ~in_empty});
    end

    always_ff @(posedge busclk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            state_q     <= IDLE;
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            mrdy_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
            mrdy_prev_q <= 1'b0;
            nwr_prev_q  <= 1'b1;
            nrd_prev_q  <= 1'b1;
            slave_rdy_q <= 1'b0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsb_q       <= 1'b0;
            act_cpol_q  <= 1'b0;
            act_cpha_q  <= 1'b0;
            act_lsb_q   <= 1'b0;
            ie_q        <= '0;
            flags_q     <= '0;
            cnt_q       <= '0;
            tx_q        <= 8'hFF;
            rx_q        <= '0;
            do_q        <= '0;
            miso_q      <= 1'b1;
            irq_q       <= 1'b0;
            out_wp_q    <= '0;
            out_rp_q    <= '0;
            in_wp_q     <= '0;
            in_rp_q     <= '0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            mrdy_sync_q <= mrdy_sync_d;
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
            mrdy_prev_q <= mrdy_s;
            nwr_prev_q  <= nWR_i;
            nrd_prev_q  <= nRD_i;
            slave_rdy_q <= slave_rdy_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            lsb_q       <= lsb_d;
            act_cpol_q  <= act_cpol_d;
            act_cpha_q  <= act_cpha_d;
            act_lsb_q   <= act_lsb_d;
            ie_q        <= ie_d;
            flags_q     <= flags_d;
            cnt_q       <= cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            do_q        <= do_d;
            miso_q      <= miso_d;
            irq_q       <= irq_d;
            out_wp_q    <= out_wp_d;
            out_rp_q    <= out_rp_d;
            in_wp_q     <= in_wp_d;
            in_rp_q     <= in_rp_d;
        end
    end

    always_ff @(posedge busclk_i) begin
        if (out_push) out_mem[out_wp_q[L-1:0]] <= D_i;
        if (in_push) in_mem[in_wp_q[L-1:0]] <= rx_d;
    end

    assign miso_o      = miso_q;
    assign slave_rdy_o = slave_rdy_q;
    assign D_o         = do_q;
    assign interrupt_o = irq_q;
endmodule

// File: tb/tb_spi_client_sync.sv
// tb_spi_client_sync: register table, directed SPI corner cases and randomized transfers against a queue-based model.
module tb_spi_client_sync;
    localparam int H = 6;
    logic busclk_i = 1'b0, n_reset_i = 1'b0, sck_i = 1'b0, cs_i = 1'b1, mosi_i = 1'b1, master_rdy_i = 1'b0;
    logic [3:0] A_i = '0;
    logic [7:0] D_i = '0;
    logic nWR_i = 1'b1, nRD_i = 1'b1;
    logic miso_o, slave_rdy_o, interrupt_o;
    logic [7:0] D_o;
    int tests = 0, fails = 0;

    typedef struct {
        logic       rd;
        logic [1:0] a;
        logic [7:0] d;
        logic [7:0] exp;
        logic       irq;
    } vec_t;
    vec_t tbl[15];

    logic [7:0] outq[$];
    logic [7:0] inq[$];
    logic [4:0] mflags;

    spi_client_sync dut (
        .busclk_i(busclk_i), .n_reset_i(n_reset_i), .sck_i(sck_i), .cs_i(cs_i), .mosi_i(mosi_i),
        .miso_o(miso_o), .slave_rdy_o(slave_rdy_o), .master_rdy_i(master_rdy_i), .A_i(A_i),
        .D_i(D_i), .D_o(D_o), .nWR_i(nWR_i), .nRD_i(nRD_i), .interrupt_o(interrupt_o)
    );

    always #5 busclk_i = ~busclk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge busclk_i);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge busclk_i);
        A_i = {2'b00, a};
        D_i = d;
        nWR_i = 1'b0;
        @(negedge busclk_i);
        nWR_i = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        @(negedge busclk_i);
        A_i = {2'b00, a};
        nRD_i = 1'b0;
        @(negedge busclk_i);
        nRD_i = 1'b1;
        d = D_o;
    endtask

    task automatic rdchk(input string name, input logic [1:0] a, input logic [7:0] exp);
        logic [7:0] r;
        rd(a, r);
        chk(name, r, exp);
    endtask

    // Master side: drives mosi and captures miso at the master's own sample point
    task automatic spi_bits(input logic [7:0] mo, input logic cpol, input logic cpha, input logic lsb,
                            input int nb, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nb; i++) begin
            if (cpha) sck_i = ~cpol;
            mosi_i = lsb ? mo[i] : mo[7-i];
            cyc(H);
            if (lsb) mi[i] = miso_o; else mi[7-i] = miso_o;
            sck_i = cpha ? cpol : ~cpol;
            cyc(H);
            if (!cpha) sck_i = cpol;
        end
    endtask

    task automatic cs_low();
        cs_i = 1'b0;
        cyc(8);
    endtask

    task automatic cs_high();
        cyc(H);
        cs_i = 1'b1;
        cyc(8);
    endtask

    task automatic model_load(output logic [7:0] v);
        if (outq.size() > 0) v = outq.pop_front();
        else begin
            v = 8'hFF;
            mflags[1] = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] r, cur, b, mo, exp;
        logic cpol, cpha, lsb;
        int n, k;
        cyc(3);
        chk("rst_miso", 8'(miso_o), 8'h01);
        chk("rst_rdy", 8'(slave_rdy_o), 8'h00);
        chk("rst_do", D_o, 8'h00);
        chk("rst_irq", 8'(interrupt_o), 8'h00);
        n_reset_i = 1'b1;
        cyc(2);

        tbl[0]  = '{1'b1, 2'd1, 8'h00, 8'h85, 1'b0};
        tbl[1]  = '{1'b0, 2'd2, 8'h02, 8'h00, 1'b1};
        tbl[2]  = '{1'b1, 2'd2, 8'h00, 8'h02, 1'b1};
        tbl[3]  = '{1'b0, 2'd0, 8'h5A, 8'h00, 1'b0};
        tbl[4]  = '{1'b1, 2'd1, 8'h00, 8'h81, 1'b0};
        tbl[5]  = '{1'b0, 2'd1, 8'h80, 8'h00, 1'b1};
        tbl[6]  = '{1'b1, 2'd1, 8'h00, 8'h85, 1'b1};
        tbl[7]  = '{1'b0, 2'd2, 8'h01, 8'h00, 1'b0};
        tbl[8]  = '{1'b1, 2'd0, 8'h00, 8'h00, 1'b0};
        tbl[9]  = '{1'b1, 2'd3, 8'h00, 8'h00, 1'b0};
        tbl[10] = '{1'b0, 2'd1, 8'h0F, 8'h00, 1'b0};
        tbl[11] = '{1'b1, 2'd1, 8'h00, 8'hC5, 1'b0};
        tbl[12] = '{1'b0, 2'd1, 8'h00, 8'h00, 1'b0};
        tbl[13] = '{1'b1, 2'd2, 8'h00, 8'h01, 1'b0};
        tbl[14] = '{1'b0, 2'd2, 8'h00, 8'h00, 1'b0};
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].rd) begin
                rd(tbl[i].a, r);
                chk($sformatf("tbl%0d_do", i), r, tbl[i].exp);
            end else wr(tbl[i].a, tbl[i].d);
            cyc(1);
            chk($sformatf("tbl%0d_irq", i), 8'(interrupt_o), 8'(tbl[i].irq));
        end

        master_rdy_i = 1'b1;
        cyc(6);
        rdchk("mrdy_flag", 2'd3, 8'h10);
        rdchk("mrdy_status", 2'd1, 8'h95);
        master_rdy_i = 1'b0;
        cyc(6);
        wr(2'd3, 8'h1F);
        rdchk("mrdy_w1c", 2'd3, 8'h00);

        wr(2'd0, 8'hA5);
        wr(2'd1, 8'h01);
        cs_low();
        spi_bits(8'h3C, 1'b0, 1'b0, 1'b0, 8, r);
        chk("m0_miso", r, 8'hA5);
        cs_high();
        rdchk("m0_rx", 2'd0, 8'h3C);
        rdchk("m0_status", 2'd1, 8'hA5);
        wr(2'd3, 8'h1F);

        sck_i = 1'b1;
        wr(2'd0, 8'h0F);
        wr(2'd1, 8'h0F);
        cs_low();
        spi_bits(8'h81, 1'b1, 1'b1, 1'b1, 8, r);
        chk("m3_miso", r, 8'h0F);
        cs_high();
        rdchk("m3_rx", 2'd0, 8'h81);
        wr(2'd1, 8'h00);
        sck_i = 1'b0;
        wr(2'd3, 8'h1F);

        wr(2'd1, 8'h01);
        cs_low();
        for (int j = 0; j < 17; j++) begin
            spi_bits(8'(j * 13 + 1), 1'b0, 1'b0, 1'b0, 8, r);
            chk($sformatf("ur_miso%0d", j), r, 8'hFF);
        end
        cs_high();
        rdchk("ovr_flags", 2'd3, 8'h0B);
        for (int j = 0; j < 16; j++) rdchk($sformatf("ovr_rx%0d", j), 2'd0, 8'(j * 13 + 1));
        rdchk("ovr_empty", 2'd0, 8'h00);
        wr(2'd3, 8'h1F);

        wr(2'd0, 8'h33);
        wr(2'd1, 8'h01);
        wr(2'd2, 8'h04);
        cs_low();
        spi_bits(8'hAA, 1'b0, 1'b0, 1'b0, 5, r);
        cs_high();
        rdchk("fr_flags", 2'd3, 8'h0C);
        chk("fr_rdy", 8'(slave_rdy_o), 8'h00);
        cyc(1);
        chk("fr_irq_on", 8'(interrupt_o), 8'h01);
        wr(2'd3, 8'h04);
        cyc(1);
        chk("fr_irq_off", 8'(interrupt_o), 8'h00);
        rdchk("fr_rx_none", 2'd0, 8'h00);
        wr(2'd2, 8'h00);
        wr(2'd3, 8'h1F);

        for (int j = 0; j < 9; j++) wr(2'd0, 8'(8'h40 + j));
        wr(2'd1, 8'h01);
        cs_low();
        for (int j = 0; j < 4; j++) begin
            spi_bits(8'(8'h10 + j), 1'b0, 1'b0, 1'b0, 8, r);
            chk($sformatf("clr_miso%0d", j), r, 8'(8'h40 + j));
        end
        cs_high();
        rdchk("clr_pre", 2'd1, 8'h80);
        wr(2'd1, 8'h81);
        chk("clr_rdy", 8'(slave_rdy_o), 8'h01);
        rdchk("clr_post", 2'd1, 8'hC5);
        wr(2'd1, 8'h00);
        wr(2'd3, 8'h1F);

        wr(2'd0, 8'h77);
        wr(2'd1, 8'h01);
        rdchk("rm_pre", 2'd1, 8'hC1);
        cs_low();
        spi_bits(8'h00, 1'b0, 1'b0, 1'b0, 3, r);
        n_reset_i = 1'b0;
        cyc(1);
        chk("rm_miso", 8'(miso_o), 8'h01);
        chk("rm_rdy", 8'(slave_rdy_o), 8'h00);
        chk("rm_do", D_o, 8'h00);
        cs_i = 1'b1;
        sck_i = 1'b0;
        n_reset_i = 1'b1;
        cyc(4);
        rdchk("rm_status", 2'd1, 8'h85);
        rdchk("rm_flags", 2'd3, 8'h00);

        mflags = '0;
        for (int it = 0; it < 20; it++) begin
            cpol = 1'($urandom);
            cpha = 1'($urandom);
            lsb = 1'($urandom);
            sck_i = cpol;
            cyc(2);
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                wr(2'd0, b);
                if (outq.size() < 16) outq.push_back(b);
            end
            wr(2'd1, {4'b0000, lsb, cpha, cpol, 1'b1});
            cs_low();
            model_load(cur);
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++) begin
                mo = 8'($urandom);
                spi_bits(mo, cpol, cpha, lsb, 8, r);
                chk($sformatf("rnd%0d_miso%0d", it, j), r, cur);
                if (inq.size() < 16) inq.push_back(mo); else mflags[0] = 1'b1;
                model_load(cur);
            end
            cs_high();
            mflags[3] = 1'b1;
            rdchk($sformatf("rnd%0d_flags", it), 2'd3, {3'b000, mflags});
            exp = {1'b1, 1'b0, |mflags[2:0], 1'b0, outq.size() == 16, outq.size() == 0,
                   inq.size() == 16, inq.size() == 0};
            rdchk($sformatf("rnd%0d_status", it), 2'd1, exp);
            while (inq.size() > 0) rdchk($sformatf("rnd%0d_rx", it), 2'd0, inq.pop_front());
            wr(2'd3, 8'h1F);
            mflags = '0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
